// File: rtl/mux51_pkg.sv
// Shared select codes and helpers for the 5:1 round-robin arbiter and its data mux.
package mux51_pkg;

  localparam int N_SRC = 5;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_A = 3'd0;
  localparam sel_t SEL_B = 3'd1;
  localparam sel_t SEL_C = 3'd2;
  localparam sel_t SEL_D = 3'd3;
  localparam sel_t SEL_E = 3'd4;

  // Step a select code to the next source, wrapping e back to a.
  function automatic sel_t sel_inc(input sel_t cur);
    sel_t nxt;
    nxt = (cur == SEL_E) ? SEL_A : cur + 3'd1;
    return nxt;
  endfunction

  // First requesting source after 'last', searching in wrap-around order.
  // With no request at all the result is 'last', which the caller ignores.
  function automatic sel_t rr_next(input logic [N_SRC-1:0] req, input sel_t last);
    sel_t cand;
    sel_t pick;
    logic found;
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = sel_inc(cand);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_SRC-1:0] sel_onehot(input sel_t sel);
    logic [N_SRC-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux51_generic.sv
// Plain 5:1 word mux steered by a mux51_pkg select code.
module mux51_generic
  import mux51_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  input  logic [width-1:0] d,
  input  logic [width-1:0] e,
  input  sel_t             sel,
  output logic [width-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      SEL_E:   y = e;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/arb51_rr.sv
// Five-source round-robin arbiter with a registered output word and valid/ready downstream.
// Define ARB51_LOCK_EN to add the 'lock' input that re-grants the last source while it still requests.
module arb51_rr
  import mux51_pkg::*;
#(
  parameter int bit_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  input  logic [bit_width-1:0] c,
  input  logic [bit_width-1:0] d,
  input  logic [bit_width-1:0] e,
  input  logic [N_SRC-1:0]     req,
`ifdef ARB51_LOCK_EN
  input  logic                 lock,
`endif
  output logic [N_SRC-1:0]     gnt,
  output sel_t                 s,
  output logic [bit_width-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready
);

  // Handshake: a word moves downstream on any edge where y_valid & y_ready.
  // The output register accepts a new word when it is empty or being drained
  // in the same cycle; otherwise y and s hold and req is ignored.

  sel_t                 last_q;
  sel_t                 nxt_sel;
  logic                 load;
  logic [bit_width-1:0] mux_y;

  always_comb begin
    load    = (|req) & (!y_valid | y_ready);
    nxt_sel = rr_next(req, last_q);
`ifdef ARB51_LOCK_EN
    if (lock && req[last_q]) begin
      nxt_sel = last_q;
    end
`endif
  end

  mux51_generic #(
    .width (bit_width)
  ) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .sel (nxt_sel),
    .y   (mux_y)
  );

  // last_q resets to e so the first search begins at a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      gnt     <= '0;
      s       <= SEL_A;
      y       <= '0;
      last_q  <= SEL_E;
    end else if (load) begin
      y_valid <= 1'b1;
      gnt     <= sel_onehot(nxt_sel);
      s       <= nxt_sel;
      y       <= mux_y;
      last_q  <= nxt_sel;
    end else begin
      gnt <= '0;
      if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb51_rr.sv
// Randomised and directed bench for arb51_rr with a queue-based scoreboard and a behavioural model.
module tb_arb51_rr;

  localparam int W = 16;
`ifdef ARB51_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] src [5];
  logic [4:0]   req;
  logic         y_ready;
  logic         lock;
  logic [4:0]   gnt;
  logic [2:0]   s;
  logic [W-1:0] y;
  logic         y_valid;

  arb51_rr #(.bit_width(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (src[0]),
    .b       (src[1]),
    .c       (src[2]),
    .d       (src[3]),
    .e       (src[4]),
    .req     (req),
`ifdef ARB51_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           ptr;
  logic         m_valid;
  logic [2:0]   m_s;
  logic [W-1:0] m_y;
  logic [W+2:0] exp_q [$];   // {source code, data word}
  logic [2:0]   seen_q [$];
  int           want_q [$];

  function automatic int pick_src(input logic [4:0] r, input int last, input bit lk);
    if (lk && r[last]) return last;
    for (int k = 1; k <= 5; k++) begin
      if (r[(last + k) % 5]) return (last + k) % 5;
    end
    return last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     = 4;
      m_valid = 1'b0;
      exp_q.delete();
    end else if (req != 5'd0 && (!m_valid || y_ready)) begin
      int p;
      p       = pick_src(req, ptr, LOCK_ON && lock);
      ptr     = p;
      m_valid = 1'b1;
      m_s     = 3'(p);
      m_y     = src[p];
      exp_q.push_back({m_s, m_y});
    end else if (y_ready) begin
      m_valid = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
      if (exp_q.size() > 0) begin
        logic [W+2:0] ex;
        ex = exp_q.pop_front();
        chk("gnt_onehot", {27'd0, gnt}, 32'd1 << ex[W+2:W]);
        chk("s_capture", {29'd0, s}, {29'd0, ex[W+2:W]});
        chk("y_capture", {16'd0, y}, {16'd0, ex[W-1:0]});
        seen_q.push_back(s);
      end else begin
        chk("gnt_idle", {27'd0, gnt}, 32'd0);
        if (m_valid) begin
          chk("s_hold", {29'd0, s}, {29'd0, m_s});
          chk("y_hold", {16'd0, y}, {16'd0, m_y});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [4:0] r, input logic rd, input logic lk);
    req     = r;
    y_ready = rd;
    lock    = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_phase();
    @(negedge clk);
    #1;
    seen_q.delete();
    want_q.delete();
  endtask

  task automatic check_seq(input string name);
    @(negedge clk);
    #1;
    chk({name, "_len"}, seen_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < seen_q.size(); i++) begin
      chk(name, {29'd0, seen_q[i]}, want_q[i]);
    end
  endtask

  initial begin
    req = '0;
    y_ready = 1'b1;
    lock = 1'b0;
    for (int i = 0; i < 5; i++) src[i] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_gnt", {27'd0, gnt}, 32'd0);
    chk("rst_s", {29'd0, s}, 32'd0);
    chk("rst_y", {16'd0, y}, 32'd0);
    rst_n = 1'b1;

    // full request: a..e then wrap to a
    begin_phase();
    for (int i = 0; i < 5; i++) src[i] = W'(i + 1);
    repeat (6) step(5'b11111, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    want_q = '{0, 1, 2, 3, 4, 0};
    check_seq("seq_all");

    // b/e alternation across the 4->0 wrap
    begin_phase();
    repeat (4) step(5'b10010, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    want_q = '{1, 4, 1, 4};
    check_seq("seq_be");

    // idle gap between bursts
    begin_phase();
    repeat (2) step(5'b11111, 1'b1, 1'b0);
    repeat (4) step(5'b00000, 1'b1, 1'b0);
    chk("idle_y_valid", {31'd0, y_valid}, 32'd0);
    repeat (2) step(5'b11111, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    want_q = '{0, 1, 2, 3};
    check_seq("seq_gap");

    // backpressure holds the captured word
    begin_phase();
    src[0] = 16'h00AA;
    step(5'b00001, 1'b1, 1'b0);
    repeat (3) step(5'b11111, 1'b0, 1'b0);
    chk("stall_y", {16'd0, y}, 32'h00AA);
    chk("stall_valid", {31'd0, y_valid}, 32'd1);
    step(5'b11111, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    want_q = '{0, 1};
    check_seq("seq_stall");

    // reset during a stalled transfer
    begin_phase();
    step(5'b11111, 1'b1, 1'b0);
    step(5'b11111, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("midrst_s", {29'd0, s}, 32'd0);
    #1;
    rst_n = 1'b1;
    seen_q.delete();
    step(5'b11111, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    want_q = '{0};
    check_seq("seq_after_rst");

    // lock holds the previous grant (pure round-robin when the feature is absent)
    begin_phase();
    repeat (3) step(5'b00101, 1'b1, 1'b1);
    step(5'b00101, 1'b1, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
`ifdef ARB51_LOCK_EN
    want_q = '{0, 0, 0, 2};
`else
    want_q = '{2, 0, 2, 0};
`endif
    check_seq("seq_lock");

    // randomised traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 5; i++) src[i] = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    step(5'b00000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
